// File: rtl/lock_pkg.sv
// Shared types and key-layout helpers for the keyed lock unit.
package lock_pkg;

    // Key-load / tamper FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        ARMED   = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_e;

    // Total key width: one bit per XOR gate plus four LUT bits per mux cell.
    function automatic int key_width(input int n_xor, input int n_mux);
        return n_xor + 4 * n_mux;
    endfunction

    // Lowest key bit of mux cell j ({p4,p3,p2,p1} sits at lo+3..lo).
    function automatic int mux_key_lo(input int n_xor, input int j);
        return n_xor + 4 * j;
    endfunction

    // Lowest data bit of the select pair driving mux cell j.
    function automatic int mux_sel_lo(input int j);
        return 2 * j;
    endfunction

    // Output bit replaced by mux cell j (cells fill from the MSB down).
    function automatic int mux_out_bit(input int data_w, input int j);
        return data_w - 1 - j;
    endfunction

endpackage

// File: rtl/lock_mux4_cell.sv
// One 4-input LUT key cell: the select pair picks one of the four key bits.
module lock_mux4_cell (
    input  logic [1:0] sel_i,
    input  logic [3:0] key_i,
    output logic       out_o
);

    // key_i = {p4,p3,p2,p1}; select 00 -> p1 ... 11 -> p4.
    always_comb begin
        case (sel_i)
            2'b00:   out_o = key_i[0];
            2'b01:   out_o = key_i[1];
            2'b10:   out_o = key_i[2];
            2'b11:   out_o = key_i[3];
            default: out_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/keyed_lock_unit.sv
// Keyed lock unit: serial key load into a shadow register with atomic commit,
// abort-count tamper lockout, and a one-cycle registered XOR/mux4 keyed datapath.
module keyed_lock_unit
    import lock_pkg::*;
#(
    parameter int DATA_W    = 36,
    parameter int N_XOR     = 8,
    parameter int N_MUX     = 4,
    parameter int MAX_ABORT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_start,
    input  logic              key_valid,
    input  logic              key_bit,
    output logic              key_ready,
    output logic              key_loaded,
    output logic              lockout,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    localparam int KEY_W = key_width(N_XOR, N_MUX);
    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam int ABT_W = $clog2(MAX_ABORT + 1);

    if ((N_XOR + N_MUX > DATA_W) || (2 * N_MUX > DATA_W) || (KEY_W < 1)) begin : g_param_err
        $error("keyed_lock_unit: illegal N_XOR/N_MUX/DATA_W combination");
    end

    lock_state_e       state_q, state_d;
    logic [KEY_W-1:0]  shadow_q, shadow_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ABT_W-1:0]  abort_cnt_q, abort_cnt_d;
    logic              key_loaded_q, key_loaded_d;
    logic              lockout_q, lockout_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [KEY_W-1:0]  shadow_shift_s;
    logic              last_bit_s;
    logic              abort_limit_s;
    logic [DATA_W-1:0] x_s;
    logic [DATA_W-1:0] keyed_s;
    logic [N_MUX-1:0]  mux_out_s;

    assign shadow_shift_s = KEY_W'({shadow_q, key_bit});
    assign last_bit_s     = (cnt_q == CNT_W'(KEY_W - 1));
    assign abort_limit_s  = (abort_cnt_q == ABT_W'(MAX_ABORT - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; an abort outranks a simultaneous final key bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ARMED: begin
                if (key_start) state_d = SHIFT;
                else           state_d = state_q;
            end
            SHIFT: begin
                if (key_start) begin
                    if (abort_limit_s) state_d = LOCKOUT;
                    else               state_d = SHIFT;
                end else if (key_valid && last_bit_s) begin
                    state_d = ARMED;
                end else begin
                    state_d = SHIFT;
                end
            end
            LOCKOUT: state_d = LOCKOUT;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and key-register updates; the active key only changes on commit or lockout.
    always_comb begin
        shadow_d     = shadow_q;
        key_d        = key_q;
        cnt_d        = cnt_q;
        abort_cnt_d  = abort_cnt_q;
        key_loaded_d = key_loaded_q;
        lockout_d    = lockout_q;
        case (state_q)
            IDLE, ARMED: begin
                if (key_start) begin
                    shadow_d = '0;
                    cnt_d    = '0;
                end else begin
                    shadow_d = shadow_q;
                end
            end
            SHIFT: begin
                if (key_start) begin
                    abort_cnt_d = abort_cnt_q + ABT_W'(1);
                    shadow_d    = '0;
                    cnt_d       = '0;
                    if (abort_limit_s) begin
                        key_d        = '0;
                        key_loaded_d = 1'b0;
                        lockout_d    = 1'b1;
                    end else begin
                        lockout_d    = 1'b0;
                    end
                end else if (key_valid) begin
                    shadow_d = shadow_shift_s;
                    if (last_bit_s) begin
                        key_d        = shadow_shift_s;
                        key_loaded_d = 1'b1;
                        abort_cnt_d  = '0;
                        cnt_d        = '0;
                    end else begin
                        cnt_d        = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            LOCKOUT: begin
                key_d        = '0;
                key_loaded_d = 1'b0;
                lockout_d    = 1'b1;
            end
            default: begin
                shadow_d = '0;
                cnt_d    = '0;
            end
        endcase
    end

    assign key_ready = (state_q == SHIFT);

    // Stage A: XOR key gates on the low data bits.
    always_comb begin
        x_s = in_data;
        for (int i = 0; i < N_XOR; i++) begin
            x_s[i] = in_data[i] ^ key_q[i];
        end
    end

    for (genvar j = 0; j < N_MUX; j++) begin : g_mux
        lock_mux4_cell u_cell (
            .sel_i (x_s[mux_sel_lo(j) +: 2]),
            .key_i (key_q[mux_key_lo(N_XOR, j) +: 4]),
            .out_o (mux_out_s[j])
        );
    end

    // Stage B: mux cell outputs replace the top data bits; everything else passes through.
    always_comb begin
        keyed_s = x_s;
        for (int j = 0; j < N_MUX; j++) begin
            keyed_s[mux_out_bit(DATA_W, j)] = mux_out_s[j];
        end
    end

    // Output register next values: zero when no usable key, hold when idle.
    always_comb begin
        out_valid_d = in_valid;
        if (in_valid) begin
            if (key_loaded_q && !lockout_q) out_data_d = keyed_s;
            else                            out_data_d = '0;
        end else begin
            out_data_d = out_data_q;
        end
    end

    // Key, counter and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q     <= '0;
            key_q        <= '0;
            cnt_q        <= '0;
            abort_cnt_q  <= '0;
            key_loaded_q <= 1'b0;
            lockout_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            shadow_q     <= shadow_d;
            key_q        <= key_d;
            cnt_q        <= cnt_d;
            abort_cnt_q  <= abort_cnt_d;
            key_loaded_q <= key_loaded_d;
            lockout_q    <= lockout_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign key_loaded = key_loaded_q;
    assign lockout    = lockout_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

endmodule
